// File: rtl/sll_arbiter.sv
// ---------------------------------------------------------------------------
// sll_arbiter
//
// Shares one logical-shift-left unit (in1 << in2) between two requesters.
// A round-robin arbiter picks at most one request per cycle; the shifted
// value is registered and presented on a valid/ready output channel tagged
// with the ID of the requester that produced it. The result register is
// reloaded in the same cycle it drains, so back-to-back operations run at
// one result per clock.
//
// Configuration macro:
//   SLL_ARBITER_FIXED_PRIO_EN - when defined, requester 0 always wins a tie
//                               and the round-robin history is dropped.
//
// Parameters:
//   L1 - width of the shifted operand and of the result
//   L2 - width of the shift-amount operand
//
// Ports:
//   clk                    clock, rising edge
//   rst_n                  asynchronous active-low reset
//   req0_valid/req0_ready  requester 0 handshake (ready is combinational)
//   req0_in1/req0_in2      requester 0 operand / shift amount
//   req1_valid/req1_ready  requester 1 handshake (ready is combinational)
//   req1_in1/req1_in2      requester 1 operand / shift amount
//   out_valid/out_ready    result channel handshake
//   out_data               shifted result, truncated to L1 bits
//   out_id                 requester that produced out_data
//   busy                   result held while the consumer stalls
// ---------------------------------------------------------------------------
module sll_arbiter #(
    parameter int L1 = 8,
    parameter int L2 = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [L1-1:0] req0_in1,
    input  logic [L2-1:0] req0_in2,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [L1-1:0] req1_in1,
    input  logic [L2-1:0] req1_in2,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [L1-1:0] out_data,
    output logic          out_id,
    output logic          busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t        state_q;
    logic [L1-1:0] out_data_q;
    logic          out_id_q;
`ifndef SLL_ARBITER_FIXED_PRIO_EN
    logic          last_grant_q;
`endif

    logic          slot_free;
    logic          any_valid;
    logic          grant;
    logic          accept;
    logic [L1-1:0] out_data_d;

    // Grant selection and the shared shifter. A shift amount of L1 or more
    // already yields zero under SystemVerilog shift semantics, and the
    // result is sized to L1, so over-range shifts and truncation need no
    // extra logic.
    always_comb begin
        slot_free = (state_q == EMPTY) || out_ready;
        any_valid = req0_valid || req1_valid;

        if (req0_valid && req1_valid) begin
`ifdef SLL_ARBITER_FIXED_PRIO_EN
            grant = 1'b0;
`else
            grant = ~last_grant_q;
`endif
        end else begin
            // Single requester wins; with none valid the value is unused.
            grant = req1_valid;
        end

        accept     = any_valid && slot_free;
        out_data_d = grant ? (req1_in1 << req1_in2) : (req0_in1 << req0_in2);
    end

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign out_valid  = (state_q == FULL);
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign busy       = (state_q == FULL) && !out_ready;

    // Result register and arbitration history. A new accept takes priority
    // over draining so FULL -> FULL happens without a bubble. last_grant
    // resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            out_data_q   <= '0;
            out_id_q     <= 1'b0;
`ifndef SLL_ARBITER_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else if (accept) begin
            state_q      <= FULL;
            out_data_q   <= out_data_d;
            out_id_q     <= grant;
`ifndef SLL_ARBITER_FIXED_PRIO_EN
            last_grant_q <= grant;
`endif
        end else if (out_ready) begin
            state_q <= EMPTY;
        end
    end

endmodule
